// File: rtl/tlram_rr_arbiter.sv
// N-host round-robin arbiter in front of a single-port SRAM.
// Uses the req/gnt/rvalid protocol; out-of-range accesses return an error.

module tlram_rr_host_dec #(
  parameter int Depth = 512,
  parameter int AW    = 9
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] word_addr,
  output logic          in_range
);
  logic unused_lo;

  assign word_addr = addr[AW+1:2];
  assign in_range  = addr[31:2] < 30'(Depth);
  assign unused_lo = ^addr[1:0];
endmodule

module tlram_rr_arbiter #(
  parameter int NumHosts    = 2,
  parameter int DataWidth   = 32,
  parameter int Depth       = 512,
  parameter int ReadLatency = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumHosts-1:0]             host_req_i,
  input  logic [NumHosts-1:0]             host_we_i,
  input  logic [NumHosts*32-1:0]          host_addr_i,
  input  logic [NumHosts*DataWidth-1:0]   host_wdata_i,
  input  logic [NumHosts*DataWidth/8-1:0] host_be_i,
  output logic [NumHosts-1:0]             host_gnt_o,
  output logic [NumHosts-1:0]             host_rvalid_o,
  output logic [NumHosts-1:0]             host_err_o,
  output logic [DataWidth-1:0]            host_rdata_o,
  output logic                            ram_req_o,
  output logic                            ram_we_o,
  output logic [$clog2(Depth)-1:0]        ram_addr_o,
  output logic [DataWidth-1:0]            ram_wdata_o,
  output logic [DataWidth-1:0]            ram_wmask_o,
  input  logic [DataWidth-1:0]            ram_rdata_i
);
  localparam int HW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int AW = $clog2(Depth);
  localparam int BW = DataWidth / 8;

  typedef struct packed {
    logic [HW-1:0] id;
    logic          err;
    logic          we;
  } rsp_t;

  logic [NumHosts-1:0][AW-1:0] word_addr;
  logic [NumHosts-1:0]         in_range;

  for (genvar h = 0; h < NumHosts; h++) begin : g_host
    tlram_rr_host_dec #(.Depth(Depth), .AW(AW)) u_dec (
      .addr      (host_addr_i[h*32 +: 32]),
      .word_addr (word_addr[h]),
      .in_range  (in_range[h])
    );
  end

  // Round-robin: scan from last_grant+1, wrapping; first requester wins.
  logic [HW-1:0] last_grant, win_id, cand;
  logic          win_vld, gnt_vld;

  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < NumHosts; i++) begin
      cand = HW'((int'(last_grant) + 1 + i) % NumHosts);
      if (!win_vld && host_req_i[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  logic          win_we;
  logic [BW-1:0] win_be;

  assign gnt_vld     = win_vld & ~rst_i;
  assign win_we      = host_we_i[win_id];
  assign win_be      = host_be_i[win_id*BW +: BW];
  assign host_gnt_o  = gnt_vld ? (NumHosts'(1) << win_id) : '0;

  assign ram_req_o   = gnt_vld & in_range[win_id];
  assign ram_we_o    = ram_req_o & win_we;
  assign ram_addr_o  = word_addr[win_id];
  assign ram_wdata_o = host_wdata_i[win_id*DataWidth +: DataWidth];

  for (genvar b = 0; b < BW; b++) begin : g_mask
    assign ram_wmask_o[b*8 +: 8] = {8{win_be[b]}};
  end

  // Response pipe: stage k holds the grant issued k cycles ago.
  logic [ReadLatency:1] vld_pipe;
  rsp_t                 rsp_pipe [1:ReadLatency];
  rsp_t                 rsp_in, rsp_out;
  logic                 rsp_vld;

  assign rsp_in = '{id: win_id, err: ~in_range[win_id], we: win_we};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= HW'(NumHosts - 1);
      vld_pipe   <= '0;
      for (int k = 1; k <= ReadLatency; k++) rsp_pipe[k] <= '0;
    end else begin
      if (gnt_vld) last_grant <= win_id;
      vld_pipe[1] <= gnt_vld;
      rsp_pipe[1] <= rsp_in;
      for (int k = 2; k <= ReadLatency; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        rsp_pipe[k] <= rsp_pipe[k-1];
      end
    end
  end

  assign rsp_out       = rsp_pipe[ReadLatency];
  assign rsp_vld       = vld_pipe[ReadLatency] & ~rst_i;
  assign host_rvalid_o = rsp_vld ? (NumHosts'(1) << rsp_out.id) : '0;
  assign host_err_o    = (rsp_vld && rsp_out.err) ? (NumHosts'(1) << rsp_out.id) : '0;
  assign host_rdata_o  = (rsp_vld && !rsp_out.err && !rsp_out.we) ? ram_rdata_i : '0;
endmodule

// File: tb/tb_tlram_rr_arbiter.sv
// Directed bench: a 2-host/latency-1 instance driven from a vector table, and a
// 3-host/latency-2 instance for ordering and reset-flush sequences.

module tb_tlram_rr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2 hosts, latency 1
  logic        rst;
  logic [1:0]  req, we, gnt, rv, err;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic [31:0] rd, ram_wdata, ram_wmask, ram_rdata;
  logic        ram_req, ram_we;
  logic [8:0]  ram_addr;

  tlram_rr_arbiter #(.NumHosts(2), .DataWidth(32), .Depth(512), .ReadLatency(1)) dut (
    .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_we_i(we), .host_addr_i(addr),
    .host_wdata_i(wdata), .host_be_i(be), .host_gnt_o(gnt), .host_rvalid_o(rv),
    .host_err_o(err), .host_rdata_o(rd), .ram_req_o(ram_req), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
    .ram_rdata_i(ram_rdata)
  );

  // 3 hosts, latency 2
  logic        r3_rst;
  logic [2:0]  r3_req, r3_gnt, r3_rv, r3_err;
  logic [95:0] r3_addr, r3_wdata;
  logic [11:0] r3_be;
  logic [31:0] r3_rd, r3_ram_wdata, r3_ram_wmask, r3_ram_rdata;
  logic        r3_ram_req, r3_ram_we;
  logic [8:0]  r3_ram_addr;

  tlram_rr_arbiter #(.NumHosts(3), .DataWidth(32), .Depth(512), .ReadLatency(2)) dut3 (
    .clk_i(clk), .rst_i(r3_rst), .host_req_i(r3_req), .host_we_i(3'b000),
    .host_addr_i(r3_addr), .host_wdata_i(r3_wdata), .host_be_i(r3_be),
    .host_gnt_o(r3_gnt), .host_rvalid_o(r3_rv), .host_err_o(r3_err),
    .host_rdata_o(r3_rd), .ram_req_o(r3_ram_req), .ram_we_o(r3_ram_we),
    .ram_addr_o(r3_ram_addr), .ram_wdata_o(r3_ram_wdata), .ram_wmask_o(r3_ram_wmask),
    .ram_rdata_i(r3_ram_rdata)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, wd;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [31:0] e_rd;
    logic        e_rreq, e_rwe;
    logic [8:0]  e_raddr;
    logic [31:0] e_wmask, e_wdata;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};

    // rst req we a0 a1 wd be rdata | gnt rv err rd rreq rwe raddr wmask wdata
    tbl[0]  = '{1, 2'b00, 2'b00, 32'h0,   32'h0,  32'h0, 4'h0, 32'h0,
                2'b00, 2'b00, 2'b00, 32'h0, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[1]  = '{0, 2'b01, 2'b00, 32'h14,  32'h0,  32'h0, 4'hF, 32'h0,
                2'b01, 2'b00, 2'b00, 32'h0, 1, 0, 9'd5, 32'hFFFFFFFF, 32'h0};
    tbl[2]  = '{0, 2'b00, 2'b00, 32'h0,   32'h0,  32'h0, 4'h0, 32'hDEADBEEF,
                2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[3]  = '{1, 2'b11, 2'b00, 32'h0,   32'h4,  32'h0, 4'hF, 32'h55555555,
                2'b00, 2'b00, 2'b00, 32'h0, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[4]  = '{0, 2'b11, 2'b00, 32'h0,   32'h4,  32'h0, 4'hF, 32'h0,
                2'b01, 2'b00, 2'b00, 32'h0, 1, 0, 9'd0, 32'hFFFFFFFF, 32'h0};
    tbl[5]  = '{0, 2'b11, 2'b00, 32'h0,   32'h4,  32'h0, 4'hF, 32'h11110000,
                2'b10, 2'b01, 2'b00, 32'h11110000, 1, 0, 9'd1, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{0, 2'b11, 2'b00, 32'h0,   32'h4,  32'h0, 4'hF, 32'h22220000,
                2'b01, 2'b10, 2'b00, 32'h22220000, 1, 0, 9'd0, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{0, 2'b11, 2'b00, 32'h0,   32'h4,  32'h0, 4'hF, 32'h33330000,
                2'b10, 2'b01, 2'b00, 32'h33330000, 1, 0, 9'd1, 32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{0, 2'b00, 2'b00, 32'h0,   32'h0,  32'h0, 4'h0, 32'h44440000,
                2'b00, 2'b10, 2'b00, 32'h44440000, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[9]  = '{0, 2'b10, 2'b10, 32'h0,   32'h10, 32'h11223344, 4'b0101, 32'h99,
                2'b10, 2'b00, 2'b00, 32'h0, 1, 1, 9'd4, 32'h00FF00FF, 32'h11223344};
    tbl[10] = '{0, 2'b00, 2'b00, 32'h0,   32'h0,  32'h0, 4'h0, 32'hFFFFFFFF,
                2'b00, 2'b10, 2'b00, 32'h0, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[11] = '{0, 2'b01, 2'b00, 32'h800, 32'h0,  32'h0, 4'hF, 32'h0,
                2'b01, 2'b00, 2'b00, 32'h0, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[12] = '{0, 2'b00, 2'b00, 32'h0,   32'h0,  32'h0, 4'h0, 32'hCAFEBABE,
                2'b00, 2'b01, 2'b01, 32'h0, 0, 0, 9'h0, 32'h0, 32'h0};
    tbl[13] = '{0, 2'b01, 2'b00, 32'h7FF, 32'h0,  32'h0, 4'hF, 32'h0,
                2'b01, 2'b00, 2'b00, 32'h0, 1, 0, 9'h1FF, 32'hFFFFFFFF, 32'h0};
    tbl[14] = '{0, 2'b00, 2'b00, 32'h0,   32'h0,  32'h0, 4'h0, 32'h12345678,
                2'b00, 2'b01, 2'b00, 32'h12345678, 0, 0, 9'h0, 32'h0, 32'h0};

    r3_rst = 1'b1; r3_req = '0; r3_ram_rdata = '0;
    r3_addr = {32'h8, 32'h4, 32'h0}; r3_wdata = '0; r3_be = '1;

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we;
      addr = {tbl[i].a1, tbl[i].a0}; wdata = {tbl[i].wd, tbl[i].wd};
      be = {tbl[i].be, tbl[i].be}; ram_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d gnt", i),    32'(gnt),     32'(tbl[i].e_gnt));
      chk($sformatf("v%0d rvalid", i), 32'(rv),      32'(tbl[i].e_rv));
      chk($sformatf("v%0d err", i),    32'(err),     32'(tbl[i].e_err));
      chk($sformatf("v%0d rdata", i),  rd,           tbl[i].e_rd);
      chk($sformatf("v%0d ram_req", i), 32'(ram_req), 32'(tbl[i].e_rreq));
      chk($sformatf("v%0d ram_we", i), 32'(ram_we),  32'(tbl[i].e_rwe));
      if (tbl[i].e_rreq) begin
        chk($sformatf("v%0d ram_addr", i),  32'(ram_addr), 32'(tbl[i].e_raddr));
        chk($sformatf("v%0d ram_wmask", i), ram_wmask,     tbl[i].e_wmask);
      end
      if (tbl[i].e_rwe) chk($sformatf("v%0d ram_wdata", i), ram_wdata, tbl[i].e_wdata);
      @(posedge clk); #1;
    end
    req = '0; rst = 1'b1;

    // Three hosts contending, latency 2: grants 0,1,2,0 and rvalid two cycles later
    r3_req = 3'b111;
    @(negedge clk);
    chk("l2 reset gnt", 32'(r3_gnt), 32'h0);
    chk("l2 reset rvalid", 32'(r3_rv), 32'h0);
    @(posedge clk); #1;
    r3_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      r3_req = (c < 4) ? 3'b111 : 3'b000;
      r3_ram_rdata = 32'hA0000000 + 32'(c);
      @(negedge clk);
      chk($sformatf("l2 c%0d gnt", c), 32'(r3_gnt), 32'(exp_g[c]));
      chk($sformatf("l2 c%0d rvalid", c), 32'(r3_rv), (c >= 2) ? 32'(exp_g[c-2]) : 32'h0);
      chk($sformatf("l2 c%0d rdata", c), r3_rd, (c >= 2) ? 32'hA0000000 + 32'(c) : 32'h0);
      @(posedge clk); #1;
    end

    // Reset the cycle after a grant: that response must never appear
    r3_rst = 1'b1; r3_req = '0;
    @(posedge clk); #1;
    r3_rst = 1'b0; r3_req = 3'b010;
    @(negedge clk);
    chk("flush pre gnt", 32'(r3_gnt), 32'h2);
    @(posedge clk); #1;
    r3_rst = 1'b1; r3_req = 3'b111;
    @(negedge clk);
    chk("flush rst gnt", 32'(r3_gnt), 32'h0);
    chk("flush rst rvalid", 32'(r3_rv), 32'h0);
    @(posedge clk); #1;
    r3_rst = 1'b0; r3_req = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("flush idle%0d rvalid", c), 32'(r3_rv), 32'h0);
      @(posedge clk); #1;
    end
    r3_req = 3'b111;
    @(negedge clk);
    chk("flush first gnt", 32'(r3_gnt), 32'h1);
    @(posedge clk); #1;
    r3_req = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush first rvalid", 32'(r3_rv), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
